// File: rtl/enc_pkg.sv
// Shared mode encodings and width helper for the parametrised priority encoder.
package enc_pkg;

    localparam logic [1:0] MODE_LSB = 2'b00;
    localparam logic [1:0] MODE_MSB = 2'b01;
    localparam logic [1:0] MODE_RR  = 2'b10;

    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational find-first over a circularly rotated request vector.
// dir_i=0 searches upward from start_i; dir_i=1 searches downward from start_i.
module prio_find
    import enc_pkg::*;
#(
    parameter int unsigned N = 16,
    localparam int unsigned W = clog2_safe(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] start_i,
    input  logic         dir_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    localparam logic [W-1:0] Last  = W'(N - 1);
    localparam logic [W:0]   NWide = (W + 1)'(N);

    logic [N-1:0] vec_n;
    logic [W-1:0] start_n;
    logic [N-1:0] rot;
    logic [W-1:0] pos;
    logic [W:0]   sum;
    logic [W-1:0] fwd;

    // A downward search is an upward search on the bit-reversed vector.
    always_comb begin
        vec_n = '0;
        for (int i = 0; i < N; i++) begin
            vec_n[i] = dir_i ? vec_i[N-1-i] : vec_i[i];
        end
        start_n = dir_i ? Last - start_i : start_i;
    end

    // Double-width rotate puts bit start_n at position 0, so the lowest set bit wins.
    always_comb begin
        rot     = N'({vec_n, vec_n} >> start_n);
        found_o = |rot;
        pos     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = W'(k);
            end
        end
        sum = {1'b0, start_n} + {1'b0, pos};
        if (sum >= NWide) begin
            sum = sum - NWide;
        end
        fwd   = sum[W-1:0];
        idx_o = '0;
        if (found_o) begin
            idx_o = dir_i ? Last - fwd : fwd;
        end
    end

endmodule

// File: rtl/param_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with LSB, MSB and round-robin selection
// and a valid/ready handshake on both sides.
module param_priority_encoder
    import enc_pkg::*;
#(
    parameter int unsigned N = 16,
    localparam int unsigned W = clog2_safe(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] ip,
    output logic [W-1:0] op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         none,
    output logic         multi
);

    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] op_q, op_d;
    logic         out_valid_q, out_valid_d;
    logic         none_q, none_d;
    logic         multi_q, multi_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept;
    logic [W-1:0] find_start;
    logic         find_dir;
    logic         found;
    logic [W-1:0] found_idx;
    logic [N-1:0] ip_dec;

    assign in_ready = en && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Reserved mode 11 falls through to fixed-LSB.
    always_comb begin
        find_start = '0;
        find_dir   = 1'b0;
        case (mode)
            MODE_MSB: begin
                find_start = Last;
                find_dir   = 1'b1;
            end
            MODE_RR: begin
                find_start = ptr_q;
            end
            default: begin
                find_start = '0;
                find_dir   = 1'b0;
            end
        endcase
    end

    prio_find #(
        .N(N)
    ) u_prio_find (
        .vec_i   (ip),
        .start_i (find_start),
        .dir_i   (find_dir),
        .found_o (found),
        .idx_o   (found_idx)
    );

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign ip_dec = ip - {{(N - 1){1'b0}}, 1'b1};

    always_comb begin
        op_d        = op_q;
        out_valid_d = out_valid_q;
        none_d      = none_q;
        multi_d     = multi_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            op_d        = found ? found_idx : '0;
            none_d      = !found;
            multi_d     = |(ip & ip_dec);
            if (mode == MODE_RR && found) begin
                ptr_d = (found_idx == Last) ? '0 : found_idx + W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            out_valid_q <= 1'b0;
            none_q      <= 1'b0;
            multi_q     <= 1'b0;
            ptr_q       <= '0;
        end else begin
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            none_q      <= none_d;
            multi_q     <= multi_d;
            ptr_q       <= ptr_d;
        end
    end

    assign op        = op_q;
    assign out_valid = out_valid_q;
    assign none      = none_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_param_priority_encoder.sv
// Scoreboard bench for param_priority_encoder: a 16-wide instance for the main
// scenarios and a 10-wide instance for odd-width wrap and asynchronous reset.
module tb_param_priority_encoder;
    import enc_pkg::*;

    typedef struct packed {
        logic [3:0] op;
        logic       none;
        logic       multi;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, in_valid, in_ready, out_valid, out_ready, none, multi;
    logic [1:0]  mode;
    logic [15:0] ip;
    logic [3:0]  op;

    logic        rst10_n, en10, in_valid10, in_ready10, out_valid10, out_ready10, none10, multi10;
    logic [1:0]  mode10;
    logic [9:0]  ip10;
    logic [3:0]  op10;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   mptr  = 0;

    param_priority_encoder #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .ip(ip), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .none(none), .multi(multi)
    );

    param_priority_encoder #(.N(10)) dut10 (
        .clk(clk), .rst_n(rst10_n), .en(en10), .mode(mode10), .in_valid(in_valid10),
        .in_ready(in_ready10), .ip(ip10), .op(op10), .out_valid(out_valid10),
        .out_ready(out_ready10), .none(none10), .multi(multi10)
    );

    // Reference model: plain linear searches, independent of the rotate structure.
    function automatic exp_t model16(input logic [15:0] v, input logic [1:0] m, input int p);
        exp_t e;
        int   cnt;
        e   = '0;
        cnt = 0;
        for (int i = 0; i < 16; i++) if (v[i]) cnt++;
        e.none  = (cnt == 0);
        e.multi = (cnt >= 2);
        if (cnt != 0) begin
            if (m == MODE_MSB) begin
                for (int i = 0; i < 16; i++) if (v[i]) e.op = 4'(i);
            end else if (m == MODE_RR) begin
                for (int k = 15; k >= 0; k--) if (v[(p + k) % 16]) e.op = 4'((p + k) % 16);
            end else begin
                for (int i = 15; i >= 0; i--) if (v[i]) e.op = 4'(i);
            end
        end
        return e;
    endfunction

    function automatic int next_ptr16(input logic [15:0] v, input logic [1:0] m, input int p);
        exp_t e;
        if (m != MODE_RR || v == 16'h0) return p;
        e = model16(v, m, p);
        return (e.op == 4'd15) ? 0 : int'(e.op) + 1;
    endfunction

    // Drives one accepted transfer on dut16 and records its expected result.
    task automatic accept16(input logic [15:0] v, input logic [1:0] m, input exp_t e);
        ip        = v;
        mode      = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sbq.push_back(e);
        mptr = next_ptr16(v, m, mptr);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00; ip = '0;
        rst10_n = 1'b0; en10 = 1'b0; in_valid10 = 1'b0; out_ready10 = 1'b0;
        mode10 = 2'b00; ip10 = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({op, out_valid, none, multi} !== 7'b0) begin
            bad++;
            $display("FAIL reset_state: got op=%0d v=%b none=%b multi=%b, want all 0",
                     op, out_valid, none, multi);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready_en0: got %b want 0", in_ready);
        end
        rst_n = 1'b1; rst10_n = 1'b1; en = 1'b1; en10 = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready_en1: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_fixed();
        logic [15:0] tip[5];
        logic [1:0]  tmode[5];
        exp_t        texp[5];
        exp_t        e;
        tip   = '{16'h0110, 16'h0110, 16'h0110, 16'h0001, 16'h8000};
        tmode = '{MODE_LSB, MODE_MSB, 2'b11, MODE_MSB, MODE_LSB};
        texp  = '{{4'd4, 1'b0, 1'b1}, {4'd8, 1'b0, 1'b1}, {4'd4, 1'b0, 1'b1},
                  {4'd0, 1'b0, 1'b0}, {4'd15, 1'b0, 1'b0}};
        for (int t = 0; t < 5; t++) begin
            accept16(tip[t], tmode[t], texp[t]);
            e = sbq.pop_front();
            total++;
            if ({out_valid, op, none, multi} !== {1'b1, e.op, e.none, e.multi}) begin
                bad++;
                $display("FAIL fixed[%0d]: got v=%b op=%0d none=%b multi=%b want v=1 op=%0d none=%b multi=%b",
                         t, out_valid, op, none, multi, e.op, e.none, e.multi);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t texp[3];
        exp_t e;
        texp = '{{4'd0, 1'b0, 1'b1}, {4'd15, 1'b0, 1'b1}, {4'd0, 1'b0, 1'b1}};
        for (int t = 0; t < 3; t++) begin
            accept16(16'h8001, MODE_RR, texp[t]);
            e = sbq.pop_front();
            total++;
            if ({out_valid, op, none, multi} !== {1'b1, e.op, e.none, e.multi}) begin
                bad++;
                $display("FAIL rr_wrap[%0d]: got v=%b op=%0d multi=%b want v=1 op=%0d multi=%b",
                         t, out_valid, op, multi, e.op, e.multi);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        accept16(16'h0020, MODE_LSB, {4'd5, 1'b0, 1'b0});
        out_ready = 1'b0; ip = 16'h0400; in_valid = 1'b1; mode = MODE_MSB;
        e = sbq.pop_front();
        total++;
        if ({out_valid, op} !== {1'b1, e.op}) begin
            bad++;
            $display("FAIL bp_first: got v=%b op=%0d want v=1 op=%0d", out_valid, op, e.op);
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || op !== 4'd5) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b op=%0d want rdy=0 v=1 op=5",
                         c, in_ready, out_valid, op);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        sbq.push_back({4'd10, 1'b0, 1'b0});
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = sbq.pop_front();
        total++;
        if ({out_valid, op, none, multi} !== {1'b1, e.op, e.none, e.multi}) begin
            bad++;
            $display("FAIL bp_next: got v=%b op=%0d want v=1 op=%0d", out_valid, op, e.op);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || op !== 4'd10) begin
            bad++;
            $display("FAIL bp_drain: got v=%b op=%0d want v=0 op=10", out_valid, op);
        end
    endtask

    task automatic test_zero_enable();
        logic [15:0] tip[2];
        exp_t        texp[2];
        exp_t        e;
        // Pointer is 1 here; a zero request must leave it there, so 0x0003 picks bit 1.
        tip  = '{16'h0000, 16'h0003};
        texp = '{{4'd0, 1'b1, 1'b0}, {4'd1, 1'b0, 1'b1}};
        for (int t = 0; t < 2; t++) begin
            accept16(tip[t], MODE_RR, texp[t]);
            e = sbq.pop_front();
            total++;
            if ({out_valid, op, none, multi} !== {1'b1, e.op, e.none, e.multi}) begin
                bad++;
                $display("FAIL zero_rr[%0d]: got v=%b op=%0d none=%b multi=%b want v=1 op=%0d none=%b multi=%b",
                         t, out_valid, op, none, multi, e.op, e.none, e.multi);
            end
        end
        en = 1'b0; in_valid = 1'b1; ip = 16'hFFFF; mode = MODE_LSB; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL en0_ready: got %b want 0", in_ready);
        end
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || op !== 4'd1 || multi !== 1'b1 || none !== 1'b0) begin
            bad++;
            $display("FAIL en0_frozen: got v=%b op=%0d none=%b multi=%b want v=0 op=1 none=0 multi=1",
                     out_valid, op, none, multi);
        end
        en = 1'b1; in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [1:0]  m;
        exp_t        e;
        for (int t = 0; t < 40; t++) begin
            v = 16'($urandom);
            if (t % 5 == 0) v = v & 16'($urandom);
            if (t % 9 == 0) v = 16'h0;
            m = 2'($urandom_range(0, 3));
            accept16(v, m, model16(v, m, mptr));
            e = sbq.pop_front();
            total++;
            if ({out_valid, op, none, multi} !== {1'b1, e.op, e.none, e.multi}) begin
                bad++;
                $display("FAIL random[%0d] ip=%h mode=%0d: got v=%b op=%0d none=%b multi=%b want v=1 op=%0d none=%b multi=%b",
                         t, v, m, out_valid, op, none, multi, e.op, e.none, e.multi);
            end
        end
    endtask

    task automatic test_odd_width_reset();
        mode10 = MODE_RR; ip10 = 10'h200; in_valid10 = 1'b1; out_ready10 = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid10, op10, none10, multi10} !== {1'b1, 4'd9, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL odd_top: got v=%b op=%0d none=%b multi=%b want v=1 op=9 none=0 multi=0",
                     out_valid10, op10, none10, multi10);
        end
        ip10 = 10'h201;
        @(negedge clk);
        total++;
        if ({out_valid10, op10, multi10} !== {1'b1, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL odd_wrap: got v=%b op=%0d multi=%b want v=1 op=0 multi=1",
                     out_valid10, op10, multi10);
        end
        @(negedge clk);
        in_valid10 = 1'b0; out_ready10 = 1'b0;
        total++;
        if (op10 !== 4'd9) begin
            bad++;
            $display("FAIL odd_rr_next: got op=%0d want 9", op10);
        end
        #2;
        rst10_n = 1'b0;
        #1;
        total++;
        if ({out_valid10, op10, none10, multi10} !== 7'b0) begin
            bad++;
            $display("FAIL odd_async_reset: got v=%b op=%0d none=%b multi=%b want all 0",
                     out_valid10, op10, none10, multi10);
        end
        @(negedge clk);
        rst10_n = 1'b1;
        in_valid10 = 1'b1; out_ready10 = 1'b1;
        @(negedge clk);
        in_valid10 = 1'b0;
        total++;
        if ({out_valid10, op10} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL odd_ptr_after_reset: got v=%b op=%0d want v=1 op=0", out_valid10, op10);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_zero_enable();
        test_random();
        test_odd_width_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
